uart_tx_arbiter: RTL and testbench



---
 rtl/uart_pkg.sv | 35 +++
 rtl/uart_tx_arbiter_rr_arb2.sv | 26 ++
 rtl/uart_tx_arbiter.sv | 162 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit arbiter slice.
//   - state encodings for the arbiter FSM (IDLE / SEND / WAIT_ACCEPT)
//   - default terminator byte appended after each record
//   - largest record size the arbiter is meant to carry
//   - helper to size the per-record byte counter
// -----------------------------------------------------------------------------
package uart_pkg;

  // Raw state encodings, kept as plain constants so other blocks (debug
  // taps, status registers) can decode the arbiter state without the enum.
  localparam logic [1:0] IDLE        = 2'd0;
  localparam logic [1:0] SEND        = 2'd1;
  localparam logic [1:0] WAIT_ACCEPT = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE        = IDLE,
    ST_SEND        = SEND,
    ST_WAIT_ACCEPT = WAIT_ACCEPT
  } arb_state_t;

  // Newline: lets a terminal or line-oriented host split records.
  localparam logic [7:0] TERM_BYTE_DEF = 8'h0A;

  // Records are 1..REC_BYTES_MAX bytes long.
  localparam int REC_BYTES_MAX = 8;

  // Byte counter must be able to hold REC_BYTES itself (count after the
  // final data byte), hence the +1.
  function automatic int cnt_width(input int rec_bytes);
    return (rec_bytes < 1) ? 1 : $clog2(rec_bytes + 1);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Combinational two-input round-robin pick.
//   i_valid0, i_valid1 : request lines from source 0 / source 1
//   i_last_grant       : index of the source granted most recently
//   o_grant_valid      : at least one source is requesting
//   o_grant_idx        : index of the source to grant (meaningful only
//                        when o_grant_valid is high)
// When both sources request, the one that was NOT granted last wins.
// -----------------------------------------------------------------------------
module rr_arb2 (
  input  logic i_valid0,
  input  logic i_valid1,
  input  logic i_last_grant,
  output logic o_grant_valid,
  output logic o_grant_idx
);

  logic w_both;

  assign w_both        = i_valid0 & i_valid1;
  assign o_grant_valid = i_valid0 | i_valid1;
  // Single requester: its own index (i_valid1 alone -> 1, i_valid0 alone -> 0).
  assign o_grant_idx   = w_both ? ~i_last_grant : i_valid1;

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one uart_tx serializer between two record sources. Records are
// granted round-robin, latched whole, and sent MSB byte first through the
// uart_tx ready / read_clock_enable handshake, optionally followed by a
// terminator byte.
//
// Parameters
//   REC_BYTES : bytes per record (1..REC_BYTES_MAX)
//   ADD_TERM  : 1 = append TERM_BYTE after each record
//   TERM_BYTE : terminator value
//
// Ports
//   clock, reset         : system clock, synchronous active-high reset
//   req0_data/valid/ack  : source 0 record, request, one-cycle latch ack
//   req1_data/valid/ack  : source 1 record, request, one-cycle latch ack
//   tx_data, tx_write    : byte and one-cycle strobe towards uart_tx
//   tx_ready             : uart_tx idle; its fall confirms a byte was taken
//   busy                 : record latched and not yet fully accepted
//   owner                : source of the current or last record
// -----------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int         REC_BYTES = 4,
  parameter bit         ADD_TERM  = 1'b1,
  parameter logic [7:0] TERM_BYTE = TERM_BYTE_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [8*REC_BYTES-1:0] req0_data,
  input  logic                   req0_valid,
  output logic                   req0_ack,
  input  logic [8*REC_BYTES-1:0] req1_data,
  input  logic                   req1_valid,
  output logic                   req1_ack,
  output logic [7:0]             tx_data,
  output logic                   tx_write,
  input  logic                   tx_ready,
  output logic                   busy,
  output logic                   owner
);

  localparam int REC_W = 8 * REC_BYTES;
  localparam int CNT_W = cnt_width(REC_BYTES);

  arb_state_t         r_state;
  logic [REC_W-1:0]   r_shift;
  logic [CNT_W-1:0]   r_byte_cnt;
  logic               r_term;
  logic               r_last_grant;
  logic               r_owner;
  logic               r_busy;
  logic               r_ack0;
  logic               r_ack1;
  logic [7:0]         r_tx_data;
  logic               r_tx_write;

  logic               w_grant_valid;
  logic               w_grant_idx;
  logic [7:0]         w_cur_byte;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_more_data;

  rr_arb2 u_rr_arb2 (
    .i_valid0      (req0_valid),
    .i_valid1      (req1_valid),
    .i_last_grant  (r_last_grant),
    .o_grant_valid (w_grant_valid),
    .o_grant_idx   (w_grant_idx)
  );

  // During the terminator phase the shift register is exhausted, so the
  // byte source switches to the constant.
  assign w_cur_byte = r_term ? TERM_BYTE : r_shift[REC_W-1 -: 8];

  // Counter only advances on data bytes and never exceeds REC_BYTES, so the
  // increment always fits in CNT_W bits.
  assign w_cnt_inc   = r_byte_cnt + 1'b1;
  assign w_more_data = (w_cnt_inc < CNT_W'(REC_BYTES));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_shift      <= '0;
      r_byte_cnt   <= '0;
      r_term       <= 1'b0;
      r_last_grant <= 1'b1;  // source 0 wins the first tie
      r_owner      <= 1'b0;
      r_busy       <= 1'b0;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_tx_data    <= 8'h00;
      r_tx_write   <= 1'b0;
    end else begin
      // Pulses: high for a single cycle unless re-armed below.
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      r_tx_write <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_grant_valid) begin
            r_shift      <= w_grant_idx ? req1_data : req0_data;
            r_byte_cnt   <= '0;
            r_term       <= 1'b0;
            r_last_grant <= w_grant_idx;
            r_owner      <= w_grant_idx;
            r_busy       <= 1'b1;
            r_ack0       <= ~w_grant_idx;
            r_ack1       <= w_grant_idx;
            r_state      <= ST_SEND;
          end
        end

        ST_SEND: begin
          if (tx_ready) begin
            r_tx_data  <= w_cur_byte;
            r_tx_write <= 1'b1;
            r_state    <= ST_WAIT_ACCEPT;
          end
        end

        ST_WAIT_ACCEPT: begin
          // uart_tx drops ready once it has taken the byte; a ready that
          // stays high keeps us here with no second strobe.
          if (!tx_ready) begin
            if (r_term) begin
              r_term  <= 1'b0;
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_shift    <= r_shift << 8;
              r_byte_cnt <= w_cnt_inc;
              if (w_more_data) begin
                r_state <= ST_SEND;
              end else if (ADD_TERM) begin
                r_term  <= 1'b1;
                r_state <= ST_SEND;
              end else begin
                r_busy  <= 1'b0;
                r_state <= ST_IDLE;
              end
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign req0_ack = r_ack0;
  assign req1_ack = r_ack1;
  assign tx_data  = r_tx_data;
  assign tx_write = r_tx_write;
  assign busy     = r_busy;
  assign owner    = r_owner;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Directed bench for uart_tx_arbiter. Instance A: REC_BYTES=4 with terminator.
// Instance B: REC_BYTES=1 without terminator. A small uart_tx model per
// instance drops ready the cycle after a strobe and raises it 20 cycles later.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // Instance A
  logic [31:0] a_req0_data, a_req1_data;
  logic        a_req0_valid, a_req1_valid;
  logic        a_req0_ack, a_req1_ack;
  logic [7:0]  a_tx_data;
  logic        a_tx_write, a_tx_ready, a_busy, a_owner;

  // Instance B
  logic [7:0]  b_req0_data, b_req1_data;
  logic        b_req0_valid, b_req1_valid;
  logic        b_req0_ack, b_req1_ack;
  logic [7:0]  b_tx_data;
  logic        b_tx_write, b_tx_ready, b_busy, b_owner;

  uart_tx_arbiter #(.REC_BYTES(4), .ADD_TERM(1'b1), .TERM_BYTE(8'h0A)) dut_a (
    .clock(clk), .reset(reset),
    .req0_data(a_req0_data), .req0_valid(a_req0_valid), .req0_ack(a_req0_ack),
    .req1_data(a_req1_data), .req1_valid(a_req1_valid), .req1_ack(a_req1_ack),
    .tx_data(a_tx_data), .tx_write(a_tx_write), .tx_ready(a_tx_ready),
    .busy(a_busy), .owner(a_owner)
  );

  uart_tx_arbiter #(.REC_BYTES(1), .ADD_TERM(1'b0), .TERM_BYTE(8'h0A)) dut_b (
    .clock(clk), .reset(reset),
    .req0_data(b_req0_data), .req0_valid(b_req0_valid), .req0_ack(b_req0_ack),
    .req1_data(b_req1_data), .req1_valid(b_req1_valid), .req1_ack(b_req1_ack),
    .tx_data(b_tx_data), .tx_write(b_tx_write), .tx_ready(b_tx_ready),
    .busy(b_busy), .owner(b_owner)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // uart_tx models
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  int  a_cnt = 0;
  int  b_cnt = 0;
  bit  a_hold = 1'b0;

  initial begin
    a_tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (a_tx_write) begin
        q_a.push_back(a_tx_data);
        a_cnt = 20;
      end else if (a_cnt > 0) begin
        a_cnt--;
      end
      a_tx_ready = !a_hold && (a_cnt == 0);
    end
  end

  initial begin
    b_tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (b_tx_write) begin
        q_b.push_back(b_tx_data);
        b_cnt = 20;
      end else if (b_cnt > 0) begin
        b_cnt--;
      end
      b_tx_ready = (b_cnt == 0);
    end
  end

  // Requester bookkeeping for instance A
  int a_ack0_cnt, a_ack1_cnt, a_first_ack;

  task automatic clear_a();
    q_a.delete();
    a_ack0_cnt  = 0;
    a_ack1_cnt  = 0;
    a_first_ack = -1;
  endtask

  task automatic poll_acks_a();
    if (a_req0_ack) begin
      a_req0_valid = 1'b0;
      a_ack0_cnt++;
      if (a_first_ack < 0) a_first_ack = 0;
    end
    if (a_req1_ack) begin
      a_req1_valid = 1'b0;
      a_ack1_cnt++;
      if (a_first_ack < 0) a_first_ack = 1;
    end
  endtask

  // Run until no request is pending and the arbiter is idle.
  task automatic run_a(input string tag, input int budget);
    int  n;
    bit  done;
    n    = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
      poll_acks_a();
      if (!a_req0_valid && !a_req1_valid && !a_busy) done = 1'b1;
    end
    check_value({tag, "_done_in_budget"}, 64'(done), 64'd1);
    $display("record set %s: %0d bytes, ack0=%0d ack1=%0d owner=%0d",
             tag, q_a.size(), a_ack0_cnt, a_ack1_cnt, a_owner);
  endtask

  task automatic check_bytes_a(input string tag, input logic [79:0] exp, input int n);
    logic [63:0] got;
    check_value({tag, "_nbytes"}, 64'(q_a.size()), 64'(n));
    for (int i = 0; i < n; i++) begin
      got = (i < q_a.size()) ? 64'(q_a[i]) : 64'hFFFF;
      check_value($sformatf("%s_byte%0d", tag, i), got, 64'(exp[8*(n-1-i) +: 8]));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nstb, b_busy_cyc, b_ack0, b_ack1;
    bit done;

    reset = 1'b1;
    a_req0_data = '0; a_req1_data = '0; a_req0_valid = 1'b0; a_req1_valid = 1'b0;
    b_req0_data = '0; b_req1_data = '0; b_req0_valid = 1'b0; b_req1_valid = 1'b0;
    clear_a();
    repeat (3) @(negedge clk);

    // Reset state
    check_value("rst_tx_write", 64'(a_tx_write), 64'd0);
    check_value("rst_tx_data",  64'(a_tx_data),  64'd0);
    check_value("rst_busy",     64'(a_busy),     64'd0);
    check_value("rst_owner",    64'(a_owner),    64'd0);
    check_value("rst_acks",     64'({a_req0_ack, a_req1_ack}), 64'd0);
    check_value("rst_b_outs",   64'({b_tx_write, b_busy, b_owner, b_req0_ack, b_req1_ack, b_tx_data}), 64'd0);

    // Simultaneous requests from reset: source 0 first
    reset = 1'b0;
    a_req0_data = 32'h01020304; a_req1_data = 32'hA0B0C0D0;
    a_req0_valid = 1'b1; a_req1_valid = 1'b1;
    run_a("pair1", 3000);
    check_bytes_a("pair1", 80'h01020304_0A_A0B0C0D0_0A, 10);
    check_value("pair1_first", 64'(a_first_ack), 64'd0);
    check_value("pair1_acks",  64'({a_ack0_cnt[7:0], a_ack1_cnt[7:0]}), 64'h0101);
    check_value("pair1_owner", 64'(a_owner), 64'd1);

    // Single record, source 0
    clear_a();
    a_req0_data = 32'hDEADBEEF; a_req0_valid = 1'b1;
    run_a("single", 2000);
    check_bytes_a("single", 80'h0000_DEADBEEF_0A, 5);
    check_value("single_ack0",  64'(a_ack0_cnt), 64'd1);
    check_value("single_ack1",  64'(a_ack1_cnt), 64'd0);
    check_value("single_owner", 64'(a_owner), 64'd0);
    check_value("single_busy",  64'(a_busy), 64'd0);

    // Next tie: last grant was source 0, so source 1 goes first
    clear_a();
    a_req0_data = 32'h0F0E0D0C; a_req1_data = 32'h1A2B3C4D;
    a_req0_valid = 1'b1; a_req1_valid = 1'b1;
    run_a("pair2", 3000);
    check_bytes_a("pair2", 80'h1A2B3C4D_0A_0F0E0D0C_0A, 10);
    check_value("pair2_first", 64'(a_first_ack), 64'd1);
    check_value("pair2_owner", 64'(a_owner), 64'd0);

    // tx_ready held low for 50 cycles after the grant
    clear_a();
    a_hold = 1'b1;
    repeat (2) @(negedge clk);
    a_req0_data = 32'h01234567; a_req0_valid = 1'b1;
    nstb = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      poll_acks_a();
      if (a_tx_write) nstb++;
    end
    check_value("hold_no_strobe", 64'(nstb), 64'd0);
    check_value("hold_ack0", 64'(a_ack0_cnt), 64'd1);
    check_value("hold_busy", 64'(a_busy), 64'd1);
    a_hold = 1'b0;
    repeat (6) @(negedge clk);
    check_value("hold_one_strobe", 64'(q_a.size()), 64'd1);
    check_value("hold_first_byte", (q_a.size() > 0) ? 64'(q_a[0]) : 64'hFFFF, 64'h01);
    run_a("hold", 2000);
    check_bytes_a("hold", 80'h0000_01234567_0A, 5);

    // Reset one cycle after the second byte's strobe
    clear_a();
    a_req0_data = 32'h11223344; a_req0_valid = 1'b1;
    nstb = 0; n = 0;
    while (nstb < 2 && n < 500) begin
      @(negedge clk);
      n++;
      poll_acks_a();
      if (a_tx_write) nstb++;
    end
    check_value("rstmid_reach_2nd", 64'(nstb), 64'd2);
    @(negedge clk);
    reset = 1'b1;
    a_req0_valid = 1'b1;  // requester keeps its record pending across reset
    @(negedge clk);
    check_value("rstmid_outs_zero",
                64'({a_tx_write, a_busy, a_owner, a_req0_ack, a_req1_ack, a_tx_data}), 64'd0);
    repeat (2) @(negedge clk);
    check_value("rstmid_held_ack", 64'(a_req0_ack), 64'd0);
    clear_a();
    reset = 1'b0;
    run_a("rstmid", 2000);
    check_bytes_a("rstmid", 80'h0000_11223344_0A, 5);
    check_value("rstmid_ack0", 64'(a_ack0_cnt), 64'd1);

    // Source 1 pulses valid for one cycle while busy
    clear_a();
    a_req0_data = 32'hCAFEF00D; a_req0_valid = 1'b1;
    n = 0;
    while (a_ack0_cnt == 0 && n < 20) begin
      @(negedge clk);
      n++;
      poll_acks_a();
    end
    a_req1_data = 32'h99887766; a_req1_valid = 1'b1;
    @(negedge clk);
    poll_acks_a();
    a_req1_valid = 1'b0;
    run_a("pulse", 2000);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      poll_acks_a();
    end
    check_bytes_a("pulse", 80'h0000_CAFEF00D_0A, 5);
    check_value("pulse_no_ack1", 64'(a_ack1_cnt), 64'd0);
    check_value("pulse_ack0",    64'(a_ack0_cnt), 64'd1);

    // Instance B: single-byte record from source 1, no terminator
    b_req1_data = 8'h55; b_req1_valid = 1'b1;
    n = 0; done = 1'b0; b_busy_cyc = 0; b_ack0 = 0; b_ack1 = 0;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
      if (b_req1_ack) begin b_req1_valid = 1'b0; b_ack1++; end
      if (b_req0_ack) b_ack0++;
      if (b_busy) b_busy_cyc++;
      if (!b_req1_valid && !b_busy && b_busy_cyc > 0) done = 1'b1;
    end
    $display("record b: %0d bytes, busy cycles=%0d, owner=%0d", q_b.size(), b_busy_cyc, b_owner);
    check_value("b_done", 64'(done), 64'd1);
    check_value("b_nbytes", 64'(q_b.size()), 64'd1);
    check_value("b_byte0", (q_b.size() > 0) ? 64'(q_b[0]) : 64'hFFFF, 64'h55);
    check_value("b_busy_ge2", 64'(b_busy_cyc >= 2), 64'd1);
    check_value("b_no_ack0", 64'(b_ack0), 64'd0);
    check_value("b_ack1", 64'(b_ack1), 64'd1);
    check_value("b_owner", 64'(b_owner), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
